// File: rtl/id_stage.sv
// Instruction decode stage: register-source selection, hazard stall, branch resolution.
// Optional macro ID_FWD_EN enables es/ms/ws operand forwarding (load-use stall only).
module id_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         fs_to_ds_valid,
  input  logic [63:0]  fs_to_ds_bus,
  output logic         ds_allowin,
  input  logic         es_allowin,
  output logic         ds_to_es_valid,
  output logic [132:0] ds_to_es_bus,
  output logic [33:0]  br_bus,
  output logic [4:0]   rf_raddr1,
  output logic [4:0]   rf_raddr2,
  input  logic [31:0]  rf_rdata1,
  input  logic [31:0]  rf_rdata2,
  input  logic [38:0]  es_fwd_bus,
  input  logic [37:0]  ms_fwd_bus,
  input  logic [37:0]  ws_fwd_bus
);

  // Handshake: a transfer happens on a rising edge where valid && allowin are both
  // high; a producer holds valid and payload steady until that edge, and allowin
  // may depend combinationally on the downstream allowin.
  logic        ds_valid;
  logic [63:0] ds_bus_q;
  logic        ds_ready_go;

  logic [31:0] inst;
  logic [31:0] pc;
  assign {inst, pc} = ds_bus_q;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  assign opcode = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign funct  = inst[5:0];
  assign imm    = inst[15:0];

  logic is_special, is_regimm, is_jr, is_jalr, is_bltz, is_bgez;
  logic is_j, is_jal, is_beq, is_bne, is_blez, is_bgtz, is_lui, is_store;
  assign is_special = (opcode == 6'h00);
  assign is_regimm  = (opcode == 6'h01);
  assign is_jr      = is_special && (funct == 6'h08);
  assign is_jalr    = is_special && (funct == 6'h09);
  assign is_bltz    = is_regimm && (rt == 5'd0);
  assign is_bgez    = is_regimm && (rt == 5'd1);
  assign is_j       = (opcode == 6'h02);
  assign is_jal     = (opcode == 6'h03);
  assign is_beq     = (opcode == 6'h04);
  assign is_bne     = (opcode == 6'h05);
  assign is_blez    = (opcode == 6'h06);
  assign is_bgtz    = (opcode == 6'h07);
  assign is_lui     = (opcode == 6'h0f);
  assign is_store   = (opcode[5:2] == 4'b1010);

  logic rs_used, rt_used, is_br_jmp;
  assign rs_used   = !(is_j || is_jal || is_lui);
  assign rt_used   = is_special || is_beq || is_bne || is_store;
  assign is_br_jmp = is_beq || is_bne || is_bgez || is_bltz || is_bgtz || is_blez ||
                     is_j || is_jal || is_jr || is_jalr;

  logic [4:0] dest;
  always_comb begin
    dest = rt;
    if (is_jal)
      dest = 5'd31;
    else if (is_jr)
      dest = 5'd0;
    else if (is_special)
      dest = rd;
    else if (is_regimm || is_beq || is_bne || is_blez || is_bgtz || is_j || is_store)
      dest = 5'd0;
  end

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  function automatic logic src_hit(input logic wr, input logic [4:0] d, input logic [4:0] src);
    return wr && (d != 5'd0) && (d == src);
  endfunction

  logic es_rs_hit, es_rt_hit, ms_rs_hit, ms_rt_hit, ws_rs_hit, ws_rt_hit;
  assign es_rs_hit = src_hit(es_fwd_bus[38], es_fwd_bus[36:32], rs);
  assign es_rt_hit = src_hit(es_fwd_bus[38], es_fwd_bus[36:32], rt);
  assign ms_rs_hit = src_hit(ms_fwd_bus[37], ms_fwd_bus[36:32], rs);
  assign ms_rt_hit = src_hit(ms_fwd_bus[37], ms_fwd_bus[36:32], rt);
  assign ws_rs_hit = src_hit(ws_fwd_bus[37], ws_fwd_bus[36:32], rs);
  assign ws_rt_hit = src_hit(ws_fwd_bus[37], ws_fwd_bus[36:32], rt);

  logic [31:0] rs_value;
  logic [31:0] rt_value;

`ifdef ID_FWD_EN
  // Youngest producer wins; only an in-flight load in EX cannot be bypassed.
  assign rs_value = es_rs_hit ? es_fwd_bus[31:0] :
                    ms_rs_hit ? ms_fwd_bus[31:0] :
                    ws_rs_hit ? ws_fwd_bus[31:0] : rf_rdata1;
  assign rt_value = es_rt_hit ? es_fwd_bus[31:0] :
                    ms_rt_hit ? ms_fwd_bus[31:0] :
                    ws_rt_hit ? ws_fwd_bus[31:0] : rf_rdata2;
  assign ds_ready_go = !(es_fwd_bus[37] && ((rs_used && es_rs_hit) || (rt_used && es_rt_hit)));
`else
  assign rs_value = rf_rdata1;
  assign rt_value = rf_rdata2;
  assign ds_ready_go = !((rs_used && (es_rs_hit || ms_rs_hit || ws_rs_hit)) ||
                         (rt_used && (es_rt_hit || ms_rt_hit || ws_rt_hit)));
  logic unused_fwd;
  assign unused_fwd = ^{es_fwd_bus[37], es_fwd_bus[31:0], ms_fwd_bus[31:0], ws_fwd_bus[31:0]};
`endif

  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go;
  assign ds_to_es_bus   = {inst, rs_value, rt_value, dest, pc};

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic        cond;
  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    target = pc_plus4 + br_off;
    cond   = 1'b0;
    if (is_beq)       cond = (rs_value == rt_value);
    else if (is_bne)  cond = (rs_value != rt_value);
    else if (is_bgez) cond = !rs_value[31];
    else if (is_bltz) cond = rs_value[31];
    else if (is_bgtz) cond = !rs_value[31] && (rs_value != 32'd0);
    else if (is_blez) cond = rs_value[31] || (rs_value == 32'd0);
    if (is_j || is_jal) begin
      target = {pc_plus4[31:28], inst[25:0], 2'b00};
      cond   = 1'b1;
    end else if (is_jr || is_jalr) begin
      target = rs_value;
      cond   = 1'b1;
    end
  end

  logic br_taken;
  logic br_stall;
  assign br_taken = ds_valid && ds_ready_go && es_allowin && cond;
  assign br_stall = ds_valid && is_br_jmp && !ds_ready_go;
  // Target is zeroed outside the taken cycle so the bus reads all-zero in reset.
  assign br_bus   = {br_stall, br_taken, br_taken ? target : 32'd0};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid <= 1'b0;
      ds_bus_q <= 64'd0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid)
        ds_bus_q <= fs_to_ds_bus;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: scenario tasks plus a scoreboard of expected EX payloads.
module tb_id_stage;
  logic         clk = 1'b0;
  logic         resetn;
  logic         fs_to_ds_valid;
  logic [63:0]  fs_to_ds_bus;
  logic         ds_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [132:0] ds_to_es_bus;
  logic [33:0]  br_bus;
  logic [4:0]   rf_raddr1;
  logic [4:0]   rf_raddr2;
  logic [31:0]  rf_rdata1;
  logic [31:0]  rf_rdata2;
  logic [38:0]  es_fwd_bus;
  logic [37:0]  ms_fwd_bus;
  logic [37:0]  ws_fwd_bus;

  id_stage dut (
    .clk(clk), .resetn(resetn),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus), .ds_allowin(ds_allowin),
    .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .br_bus(br_bus), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .es_fwd_bus(es_fwd_bus), .ms_fwd_bus(ms_fwd_bus), .ws_fwd_bus(ws_fwd_bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [132:0] exp_q[$];

  function automatic logic [132:0] make_bus(input logic [31:0] i, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] d,
                                            input logic [31:0] p);
    return {i, a, b, d, p};
  endfunction

  // scoreboard: every EX transfer must match the oldest expected payload
  always @(negedge clk) begin
    logic [132:0] e;
    if (resetn === 1'b1 && ds_to_es_valid === 1'b1 && es_allowin === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%h required=none", ds_to_es_bus);
      end else begin
        e = exp_q.pop_front();
        if (ds_to_es_bus !== e) begin
          bad++;
          $display("FAIL sb_payload got=%h required=%h", ds_to_es_bus, e);
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {i, p};
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    es_allowin = 1'b1;
    rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
    es_fwd_bus = '0; ms_fwd_bus = '0; ws_fwd_bus = '0;
    send(32'h24080005, 32'h00000040);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ds_to_es_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b required=0", ds_to_es_valid); end
    total++; if (br_bus !== 34'd0) begin bad++; $display("FAIL rst_br_bus got=%h required=0", br_bus); end
    total++; if (ds_allowin !== 1'b1) begin bad++; $display("FAIL rst_allowin got=%b required=1", ds_allowin); end
    next_cycle();
    resetn = 1'b1;
    fs_to_ds_valid = 1'b0;
    @(negedge clk);
    total++; if (ds_to_es_valid !== 1'b0) begin bad++; $display("FAIL rst_no_capture got=%b required=0", ds_to_es_valid); end
  endtask

  task automatic test_basic();
    next_cycle();
    rf_rdata1 = 32'd0; rf_rdata2 = 32'h5555;
    send(32'h24080005, 32'hbfc00000);
    exp_q.push_back(make_bus(32'h24080005, 32'd0, 32'h5555, 5'd8, 32'hbfc00000));
    next_cycle();
    fs_to_ds_valid = 1'b0;
    @(negedge clk);
    total++; if (ds_to_es_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b required=1", ds_to_es_valid); end
    total++; if (ds_to_es_bus[36:32] !== 5'd8) begin bad++; $display("FAIL basic_dest got=%0d required=8", ds_to_es_bus[36:32]); end
    total++; if (ds_to_es_bus[31:0] !== 32'hbfc00000) begin bad++; $display("FAIL basic_pc got=%h required=bfc00000", ds_to_es_bus[31:0]); end
    total++; if (rf_raddr2 !== 5'd8) begin bad++; $display("FAIL basic_raddr2 got=%0d required=8", rf_raddr2); end
    next_cycle();
    @(negedge clk);
    total++; if (ds_to_es_valid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b required=0", ds_to_es_valid); end
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic        tk;
    logic [31:0] tgt;
    logic [4:0]  dest;
  } br_vec_t;

  task automatic test_branch();
    br_vec_t v[12];
    v[0]  = {32'h10220003, 32'hbfc00010, 32'd7, 32'd7, 1'b1, 32'hbfc00020, 5'd0};
    v[1]  = {32'h10220003, 32'hbfc00010, 32'd7, 32'd8, 1'b0, 32'h0, 5'd0};
    v[2]  = {32'h1422ffff, 32'h00000100, 32'd1, 32'd2, 1'b1, 32'h00000100, 5'd0};
    v[3]  = {32'h04210002, 32'h00001000, 32'hffffffff, 32'd0, 1'b0, 32'h0, 5'd0};
    v[4]  = {32'h04200002, 32'h00001000, 32'hffffffff, 32'd0, 1'b1, 32'h0000100c, 5'd0};
    v[5]  = {32'h1c200001, 32'h00002000, 32'd0, 32'd0, 1'b0, 32'h0, 5'd0};
    v[6]  = {32'h18200001, 32'h00002000, 32'd0, 32'd0, 1'b1, 32'h00002008, 5'd0};
    v[7]  = {32'h08000004, 32'hbfc00000, 32'd0, 32'd0, 1'b1, 32'hb0000010, 5'd0};
    v[8]  = {32'h0c000004, 32'hfffffffc, 32'd0, 32'd0, 1'b1, 32'h00000010, 5'd31};
    v[9]  = {32'h00200008, 32'h00003000, 32'h12345678, 32'd0, 1'b1, 32'h12345678, 5'd0};
    v[10] = {32'h0020f809, 32'h00003000, 32'h87654320, 32'd0, 1'b1, 32'h87654320, 5'd31};
    v[11] = {32'h10220001, 32'hfffffff8, 32'd5, 32'd5, 1'b1, 32'h00000000, 5'd0};
    es_allowin = 1'b1;
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      rf_rdata1 = v[k].a; rf_rdata2 = v[k].b;
      send(v[k].inst, v[k].pc);
      exp_q.push_back(make_bus(v[k].inst, v[k].a, v[k].b, v[k].dest, v[k].pc));
      next_cycle();
      fs_to_ds_valid = 1'b0;
      @(negedge clk);
      total++;
      if (br_bus[32] !== v[k].tk) begin bad++; $display("FAIL br_taken[%0d] got=%b required=%b", k, br_bus[32], v[k].tk); end
      if (v[k].tk) begin
        total++;
        if (br_bus[31:0] !== v[k].tgt) begin bad++; $display("FAIL br_target[%0d] got=%h required=%h", k, br_bus[31:0], v[k].tgt); end
      end
      total++;
      if (br_bus[33] !== 1'b0) begin bad++; $display("FAIL br_stall[%0d] got=%b required=0", k, br_bus[33]); end
      next_cycle();
      @(negedge clk);
      total++;
      if (br_bus[32] !== 1'b0) begin bad++; $display("FAIL br_one_cycle[%0d] got=%b required=0", k, br_bus[32]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [132:0] a_exp;
    a_exp = make_bus(32'h00221821, 32'ha, 32'hb, 5'd3, 32'h400);
    next_cycle();
    rf_rdata1 = 32'ha; rf_rdata2 = 32'hb;
    es_allowin = 1'b1;
    send(32'h00221821, 32'h400);
    exp_q.push_back(a_exp);
    next_cycle();
    es_allowin = 1'b0;
    send(32'h34040001, 32'h404);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      total++; if (ds_allowin !== 1'b0) begin bad++; $display("FAIL hold_allowin[%0d] got=%b required=0", k, ds_allowin); end
      total++; if (ds_to_es_bus !== a_exp) begin bad++; $display("FAIL hold_bus[%0d] got=%h required=%h", k, ds_to_es_bus, a_exp); end
    end
    next_cycle();
    es_allowin = 1'b1;
    exp_q.push_back(make_bus(32'h34040001, 32'ha, 32'hb, 5'd4, 32'h404));
    @(negedge clk);
    total++; if (ds_allowin !== 1'b1) begin bad++; $display("FAIL release_allowin got=%b required=1", ds_allowin); end
    next_cycle();
    fs_to_ds_valid = 1'b0;
    @(negedge clk);
    total++; if (ds_to_es_bus[36:32] !== 5'd4) begin bad++; $display("FAIL b2b_dest got=%0d required=4", ds_to_es_bus[36:32]); end
    next_cycle();
    @(negedge clk);
    total++; if (ds_to_es_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b required=0", ds_to_es_valid); end
  endtask

`ifndef ID_FWD_EN
  task automatic test_hazard();
    next_cycle();
    rf_rdata1 = 32'd3; rf_rdata2 = 32'd0;
    es_allowin = 1'b0;
    es_fwd_bus = {1'b1, 1'b0, 5'd0, 32'h1};
    ms_fwd_bus = {1'b0, 5'd5, 32'h2};
    send(32'h14a00002, 32'h500);
    next_cycle();
    fs_to_ds_valid = 1'b0;
    @(negedge clk);
    total++; if (br_bus[33] !== 1'b0) begin bad++; $display("FAIL hz_nomatch_stall got=%b required=0", br_bus[33]); end
    total++; if (ds_to_es_valid !== 1'b1) begin bad++; $display("FAIL hz_nomatch_valid got=%b required=1", ds_to_es_valid); end
    next_cycle();
    ws_fwd_bus = {1'b1, 5'd5, 32'hdead};
    @(negedge clk);
    total++; if (br_bus[33] !== 1'b1) begin bad++; $display("FAIL hz_ws_stall got=%b required=1", br_bus[33]); end
    total++; if (ds_to_es_valid !== 1'b0) begin bad++; $display("FAIL hz_ws_valid got=%b required=0", ds_to_es_valid); end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      es_allowin = 1'b1;
      @(negedge clk);
      total++; if (ds_allowin !== 1'b0) begin bad++; $display("FAIL hz_allowin[%0d] got=%b required=0", k, ds_allowin); end
      total++; if (br_bus[32] !== 1'b0) begin bad++; $display("FAIL hz_taken_early[%0d] got=%b required=0", k, br_bus[32]); end
    end
    next_cycle();
    ws_fwd_bus = '0;
    exp_q.push_back(make_bus(32'h14a00002, 32'd3, 32'd0, 5'd0, 32'h500));
    @(negedge clk);
    total++; if (br_bus[33:32] !== 2'b01) begin bad++; $display("FAIL hz_release got=%b required=01", br_bus[33:32]); end
    total++; if (br_bus[31:0] !== 32'h50c) begin bad++; $display("FAIL hz_target got=%h required=0000050c", br_bus[31:0]); end
    next_cycle();
    es_fwd_bus = '0; ms_fwd_bus = '0;
  endtask
`else
  task automatic test_fwd();
    next_cycle();
    rf_rdata1 = 32'h33; rf_rdata2 = 32'h44;
    es_allowin = 1'b0;
    es_fwd_bus = {1'b1, 1'b0, 5'd9, 32'h11};
    ms_fwd_bus = {1'b1, 5'd9, 32'h22};
    send(32'h01204021, 32'h600);
    next_cycle();
    fs_to_ds_valid = 1'b0;
    @(negedge clk);
    total++; if (ds_to_es_bus[100:69] !== 32'h11) begin bad++; $display("FAIL fwd_rs got=%h required=00000011", ds_to_es_bus[100:69]); end
    total++; if (ds_to_es_valid !== 1'b1) begin bad++; $display("FAIL fwd_valid got=%b required=1", ds_to_es_valid); end
    next_cycle();
    es_allowin = 1'b1;
    es_fwd_bus = {1'b1, 1'b1, 5'd9, 32'h11};
    @(negedge clk);
    total++; if (ds_to_es_valid !== 1'b0) begin bad++; $display("FAIL fwd_load_valid got=%b required=0", ds_to_es_valid); end
    total++; if (ds_allowin !== 1'b0) begin bad++; $display("FAIL fwd_load_allowin got=%b required=0", ds_allowin); end
    next_cycle();
    es_fwd_bus = {1'b1, 1'b0, 5'd9, 32'h11};
    exp_q.push_back(make_bus(32'h01204021, 32'h11, 32'h44, 5'd8, 32'h600));
    @(negedge clk);
    total++; if (ds_to_es_valid !== 1'b1) begin bad++; $display("FAIL fwd_release got=%b required=1", ds_to_es_valid); end
    next_cycle();
    es_fwd_bus = '0; ms_fwd_bus = '0;
  endtask
`endif

  task automatic test_reset_stall();
    next_cycle();
    es_allowin = 1'b1;
    rf_rdata1 = 32'd1; rf_rdata2 = 32'd1;
    es_fwd_bus = {1'b1, 1'b1, 5'd7, 32'h0};
    send(32'h10c70001, 32'h700);
    next_cycle();
    fs_to_ds_valid = 1'b0;
    @(negedge clk);
    total++; if (br_bus[33] !== 1'b1) begin bad++; $display("FAIL rs_stall got=%b required=1", br_bus[33]); end
    #2 resetn = 1'b0;
    #1;
    total++; if (ds_to_es_valid !== 1'b0) begin bad++; $display("FAIL rs_async_valid got=%b required=0", ds_to_es_valid); end
    total++; if (br_bus !== 34'd0) begin bad++; $display("FAIL rs_async_br got=%h required=0", br_bus); end
    total++; if (ds_allowin !== 1'b1) begin bad++; $display("FAIL rs_async_allowin got=%b required=1", ds_allowin); end
    next_cycle();
    es_fwd_bus = '0;
    resetn = 1'b1;
    @(negedge clk);
    total++; if (ds_to_es_valid !== 1'b0) begin bad++; $display("FAIL rs_discard got=%b required=0", ds_to_es_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_back_to_back();
`ifndef ID_FWD_EN
    test_hazard();
`else
    test_fwd();
`endif
    test_reset_stall();
    repeat (2) next_cycle();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d required=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have ports: clk in 1 system clock; resetn in 1 asynchronous active-low reset.
REQ-002 fs_to_ds_valid in 1, IF output valid; fs_to_ds_bus in 64, {inst[63:32], pc[31:0]}; ds_allowin out 1, ID can accept.
REQ-003 es_allowin in 1, EX can accept; ds_to_es_valid out 1; ds_to_es_bus out 133, {inst[132:101], rs_value[100:69], rt_value[68:37], dest[36:32], pc[31:0]}.
REQ-004 br_bus out 34, {br_stall[33], br_taken[32], br_target[31:0]}.
REQ-005 rf_raddr1 out 5 = inst[25:21]; rf_raddr2 out 5 = inst[20:16]; rf_rdata1, rf_rdata2 in 32, combinational register-file read data.
REQ-006 es_fwd_bus in 39 {wr_valid[38], is_load[37], dest[36:32], result[31:0]}; ms_fwd_bus, ws_fwd_bus in 38 {wr_valid[37], dest[36:32], result[31:0]}.

Function
REQ-007 Handshake: ds_allowin = !ds_valid || (ds_ready_go && es_allowin); ds_to_es_valid = ds_valid && ds_ready_go.
REQ-008 When ds_allowin is high, the block SHALL load ds_valid <= fs_to_ds_valid and, if fs_to_ds_valid, capture fs_to_ds_bus, taking effect the next cycle.
REQ-009 When ds_allowin is low, ds_valid and the captured bus SHALL hold unchanged.
REQ-010 Decode: rs_used is true for all except j, jal, lui. rt_used is true for SPECIAL (opcode 0), beq, bne, and stores (opcode 0x28-0x2B).
REQ-011 dest: 31 for jal; rd for SPECIAL (including jalr); 0 for jr, branches, j, and stores; otherwise rt.
REQ-012 A producer matches a source when wr_valid=1, its dest is non-zero, and it equals that source's register number.
REQ-013 Hazard (macro absent): ds_ready_go = 0 while any es/ms/ws match exists on a used source; otherwise 1.
REQ-014 Branches: beq, bne, bgez, bltz, bgtz, blez use targets pc+4+(sext(imm16)<<2); j and jal use {pc+4[31:28], inst[25:0], 2'b00}; jr and jalr use rs_value.
REQ-015 Comparisons SHALL be 32-bit signed on rs_value, or rs_value vs rt_value for beq/bne; jumps are always taken.
REQ-016 br_taken = ds_valid && ds_ready_go && es_allowin && branch_condition_true. It is asserted for exactly the handshake cycle.
REQ-017 br_stall = ds_valid && is_branch_or_jump && !ds_ready_go.
REQ-018 br_target SHALL be valid whenever br_taken is high and don't-care otherwise.
REQ-019 Simultaneous ds_to_es fire and new capture SHALL be lossless: the old instruction leaves and the new one is loaded in the same edge.
REQ-020 pc wraps modulo 2^32 in all target arithmetic.

Reset
REQ-021 While resetn=0, the block SHALL asynchronously clear ds_valid and the captured bus to 0.
REQ-022 During reset, ds_to_es_valid=0, br_bus=0, and ds_allowin=1; the first capture occurs on the first edge after deassertion.
REQ-023 A reset asserted mid-stall SHALL discard the held instruction.

Configuration
REQ-024 Macro ID_FWD_EN: when defined, the block SHALL forward the source value from the highest-priority match, es > ms > ws, else rf_rdata.
REQ-025 With ID_FWD_EN defined, ds_ready_go = 0 only when an es match exists with is_load=1 (load-use); forwarded values feed both the bus and the branch compare.
REQ-026 With ID_FWD_EN undefined, rs_value = rf_rdata1, rt_value = rf_rdata2, and REQ-013 applies.

Verification
REQ-027 Reset release, IF sends inst 0x24080005 (addiu $8,$0,5) at pc 0xbfc00000 -> next cycle ds_to_es_valid=1, dest=8, pc=0xbfc00000.
REQ-028 beq $1,$2 with rf_rdata1=rf_rdata2=7 at pc 0xbfc00010, imm 0x0003, es_allowin=1 -> br_taken=1, br_target=0xbfc00020, for one cycle.
REQ-029 es_allowin=0 for 3 cycles with a valid instruction held -> ds_allowin=0 and ds_to_es_bus unchanged; the fourth cycle transfers.
REQ-030 (macro absent) ws_fwd_bus {1,rs=5,...} with bne using $5 -> br_stall=1, ds_ready_go=0 until ws clears, then br_taken evaluated.
REQ-031 (ID_FWD_EN) es {wr,0,dest 9,0x11} with ms {wr,dest 9,0x22} and addu using $9 -> rs_value=0x11; es is_load=1 -> one-cycle stall.
REQ-032 resetn asserted while stalled on a hazard -> ds_valid=0 immediately, br_bus=0.
